sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
// PURPOSE
// - Shares the single sdram_controller host interface (wr/rd addr, data, enables, busy, rd_ready) between two requesters in the clk_130mhz domain.
// - Port 0 = CPU-side bridge, port 1 = video/DMA fetch; one 16-bit transfer per grant.
// - Sequences each access: issue enable, confirm acceptance via busy, wait completion, return read data and a done pulse.
// PARAMETERS
// - ADDR_WIDTH      24  halfword address width (matches controller wr_addr/rd_addr)
// - DATA_WIDTH      16  transfer width
// - ACCEPT_TIMEOUT  8   cycles to wait for busy to rise after an enable before re-issuing
// - STARVE_LIMIT    4   consecutive port-1 grants while port 0 waits before port 0 is forced (macro only)
// PORTS
// - clk_130mhz     in   1           sole clock
// - reset          in   1           synchronous, active-high
// - req0_valid     in   1           port 0 request; held with req0_we/addr/wdata until req0_done
// - req0_we        in   1           1 = write, 0 = read
// - req0_addr      in   ADDR_WIDTH  halfword address
// - req0_wdata     in   DATA_WIDTH  write data
// - req0_done      out  1           1-cycle pulse: transfer complete
// - req0_rdata     out  DATA_WIDTH  read data, valid in req0_done cycle, held until next port-0 read completes
// - req1_*         --   --          identical set for port 1
// - ctl_addr       out  ADDR_WIDTH  to controller wr_addr and rd_addr
// - ctl_wdata      out  DATA_WIDTH  to controller wr_data
// - ctl_wr_enable  out  1           to controller wr_enable
// - ctl_rd_enable  out  1           to controller rd_enable
// - ctl_busy       in   1           controller busy
// - ctl_rd_ready   in   1           controller rd_ready
// - ctl_rd_data    in   DATA_WIDTH  controller rd_data
// - grant          out  1           index of port owning current/last transfer
// - arb_active     out  1           high in every state except IDLE
// BEHAVIOUR
// - Reset: state=IDLE; ctl_wr_enable, ctl_rd_enable, req*_done, arb_active=0; ctl_addr, ctl_wdata, req*_rdata=0; grant=1 (so port 0 wins first tie).
// - Reset mid-transfer aborts immediately; no done pulse; the controller is reset separately.
// - FSM:
//   - IDLE: if any reqN_valid and !ctl_busy, choose winner, latch addr/we/wdata into internal regs, -> ISSUE.
//   - ISSUE: assert ctl_wr_enable (we=1) or ctl_rd_enable (we=0) for exactly 1 cycle from the latched regs; clear timer; -> WAIT_ACCEPT.
//   - WAIT_ACCEPT: ctl_busy=1 -> WAIT_DONE; timer reaching ACCEPT_TIMEOUT -> ISSUE (re-issue, same op).
//   - WAIT_DONE, write: ctl_busy=0 -> DONE.
//   - WAIT_DONE, read: ctl_rd_ready=1 -> capture ctl_rd_data into reqN_rdata -> DONE. A rd_ready in the same cycle busy rises is also accepted (-> DONE direct from WAIT_ACCEPT).
//   - DONE: pulse reqN_done 1 cycle -> IDLE.
// - Latency:
//   - Request to enable: 2 cycles (IDLE latch, ISSUE).
//   - Completion event to done: 1 cycle.
//   - Minimum idle gap between grants: 1 cycle, so a requester can deassert valid after done.
// - Arbitration is round-robin, decided only in IDLE:
//   - Both valid: winner = !grant.
//   - Single valid: that port wins.
//   - grant updates at latch.
// - ctl_addr/ctl_wdata are driven from latched regs and stay stable from ISSUE until the next latch.
// - Requester changing inputs mid-transfer has no effect (latched). Dropping valid before done is illegal; done still pulses.
// - Timer width clog2(ACCEPT_TIMEOUT+1); saturates, no wrap.
// CONFIGURATION
// - SDRAM_ARB_PRIORITY_EN defined:
//   - Port 1 has strict priority.
//   - A starvation counter increments on each port-1 grant while req0_valid is high and resets on a port-0 grant.
//   - At STARVE_LIMIT the next IDLE decision goes to port 0 regardless.
// - Undefined: pure round-robin; counter not instantiated.
// TESTING
// - Single port-0 write addr=0x000123 data=0xBEEF -> ctl_wr_enable 1 cycle with ctl_addr=0x000123, ctl_wdata=0xBEEF; req0_done after busy falls.
// - Port-1 read addr=0x000010, model returns 0x1234 on rd_ready -> req1_rdata=0x1234 in the req1_done cycle; rdata held afterwards.
// - Both ports request continuously, 6 transfers -> grant order 0,1,0,1,0,1 (macro off); with macro and STARVE_LIMIT=4 -> 1,1,1,1,0,1.
// - Model ignores first enable (busy stays 0) -> enable re-issued exactly ACCEPT_TIMEOUT+1 cycles after first; one done only.
// - reset asserted during WAIT_DONE of a read -> next cycle all outputs at reset values, no done; next request served normally.
// - ctl_busy high in IDLE with req0_valid -> no enable until busy low, then ISSUE.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Two-port round-robin arbiter in front of the sdram_controller host interface; SDRAM_ARB_PRIORITY_EN gives port 1 strict priority with a port-0 starvation guard.
// Latency: request to ctl enable 2 cycles, controller completion to reqN_done 1 cycle, at least 1 idle cycle between grants.
// Backpressure: requesters hold valid until done; a new grant waits for ctl_busy low, and an enable not acknowledged by busy is re-issued.
module sdram_port_arbiter #(
  parameter int ADDR_WIDTH     = 24,
  parameter int DATA_WIDTH     = 16,
  parameter int ACCEPT_TIMEOUT = 8,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                  clk_130mhz,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_done,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_done,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic [ADDR_WIDTH-1:0] ctl_addr,
  output logic [DATA_WIDTH-1:0] ctl_wdata,
  output logic                  ctl_wr_enable,
  output logic                  ctl_rd_enable,
  input  logic                  ctl_busy,
  input  logic                  ctl_rd_ready,
  input  logic [DATA_WIDTH-1:0] ctl_rd_data,
  output logic                  grant,
  output logic                  arb_active
);

  localparam int TW = $clog2(ACCEPT_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACCEPT,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          lat_we;
  logic          take;
  logic          capture;
  logic          winner;

`ifdef SDRAM_ARB_PRIORITY_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  // Port 1 wins outright unless port 0 has been passed over STARVE_LIMIT times.
  always_comb begin
    winner = 1'b0;
    if (req0_valid && starve_cnt >= SW'(STARVE_LIMIT)) winner = 1'b0;
    else if (req1_valid)                                winner = 1'b1;
  end

  always_ff @(posedge clk_130mhz) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (take) begin
      if (!winner)
        starve_cnt <= '0;
      else if (req0_valid && starve_cnt != SW'(STARVE_LIMIT))
        starve_cnt <= starve_cnt + SW'(1);
    end
  end
`else
  always_comb begin
    winner = req1_valid;
    if (req0_valid && req1_valid) winner = ~grant;
  end
`endif

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    take      = 1'b0;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if ((req0_valid || req1_valid) && !ctl_busy) begin
          take      = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_nxt = '0;
        state_nxt = S_WAIT_ACCEPT;
      end
      S_WAIT_ACCEPT: begin
        if (ctl_busy) begin
          // A read can complete in the same cycle the controller reports busy.
          if (!lat_we && ctl_rd_ready) begin
            capture   = 1'b1;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_WAIT_DONE;
          end
        end else begin
          if (timer != TW'(ACCEPT_TIMEOUT)) timer_nxt = timer + TW'(1);
          if (timer >= TW'(ACCEPT_TIMEOUT - 1)) state_nxt = S_ISSUE;
        end
      end
      S_WAIT_DONE: begin
        if (lat_we) begin
          if (!ctl_busy) state_nxt = S_DONE;
        end else if (ctl_rd_ready) begin
          capture   = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_130mhz) begin
    if (reset) begin
      state      <= S_IDLE;
      timer      <= '0;
      lat_we     <= 1'b0;
      ctl_addr   <= '0;
      ctl_wdata  <= '0;
      grant      <= 1'b1;
      req0_rdata <= '0;
      req1_rdata <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      if (take) begin
        grant     <= winner;
        lat_we    <= winner ? req1_we    : req0_we;
        ctl_addr  <= winner ? req1_addr  : req0_addr;
        ctl_wdata <= winner ? req1_wdata : req0_wdata;
      end
      if (capture) begin
        if (grant) req1_rdata <= ctl_rd_data;
        else       req0_rdata <= ctl_rd_data;
      end
    end
  end

  assign ctl_wr_enable = (state == S_ISSUE) &&  lat_we;
  assign ctl_rd_enable = (state == S_ISSUE) && !lat_we;
  assign req0_done     = (state == S_DONE)  && !grant;
  assign req1_done     = (state == S_DONE)  &&  grant;
  assign arb_active    = (state != S_IDLE);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: controller model plus per-port scoreboards checked on enables and done pulses.
module tb_sdram_port_arbiter;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int AT = 8;
`ifdef SDRAM_ARB_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk_130mhz, reset;
  logic req0_valid, req0_we, req0_done, req1_valid, req1_we, req1_done;
  logic [AW-1:0] req0_addr, req1_addr, ctl_addr;
  logic [DW-1:0] req0_wdata, req0_rdata, req1_wdata, req1_rdata, ctl_wdata, ctl_rd_data;
  logic ctl_wr_enable, ctl_rd_enable, ctl_busy, ctl_rd_ready, grant, arb_active;

  sdram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACCEPT_TIMEOUT(AT), .STARVE_LIMIT(4)) dut (
    .clk_130mhz(clk_130mhz), .reset(reset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_done(req0_done), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_done(req1_done), .req1_rdata(req1_rdata),
    .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata), .ctl_wr_enable(ctl_wr_enable), .ctl_rd_enable(ctl_rd_enable),
    .ctl_busy(ctl_busy), .ctl_rd_ready(ctl_rd_ready), .ctl_rd_data(ctl_rd_data),
    .grant(grant), .arb_active(arb_active)
  );

  initial begin
    clk_130mhz = 1'b0;
    forever #4 clk_130mhz = ~clk_130mhz;
  end

  int cyc = 0;
  always @(posedge clk_130mhz) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mdata(input logic [23:0] a);
    if (a == 24'h000010) return 16'h1234;
    return {a[7:0], ~a[7:0]};
  endfunction

  // Controller model: busy for 3 cycles after an accepted enable; reads return rd_ready in the last busy cycle.
  logic m_busy = 1'b0, m_rd_ready = 1'b0, force_busy = 1'b0, m_is_rd = 1'b0;
  logic [15:0] m_rd_data = '0;
  logic [23:0] m_addr = '0;
  int m_cnt = 0, ign_target = 0, ign_seen = 0;
  assign ctl_busy     = m_busy | force_busy;
  assign ctl_rd_ready = m_rd_ready;
  assign ctl_rd_data  = m_rd_data;

  initial forever begin
    @(negedge clk_130mhz);
    m_rd_ready = 1'b0;
    if (reset) begin
      m_busy = 1'b0;
      m_cnt  = 0;
    end else if (m_busy) begin
      if (m_cnt == 2 && m_is_rd) begin
        m_rd_ready = 1'b1;
        m_rd_data  = mdata(m_addr);
      end
      if (m_cnt == 1) m_busy = 1'b0;
      m_cnt--;
    end else if (ctl_wr_enable || ctl_rd_enable) begin
      if (ign_seen < ign_target) ign_seen++;
      else begin
        m_busy  = 1'b1;
        m_cnt   = 3;
        m_is_rd = ctl_rd_enable;
        m_addr  = ctl_addr;
      end
    end
  end

  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  function automatic bit en_match(input exp_t e);
    return (e.we == ctl_wr_enable) && (e.addr == ctl_addr) && (!e.we || e.wdata == ctl_wdata);
  endfunction

  int en_cnt = 0, en_last_cyc = 0, en_prev_cyc = 0;
  logic prev_en = 1'b0;
  initial forever begin
    @(negedge clk_130mhz);
    if (ctl_wr_enable || ctl_rd_enable) begin
      chk("en_single_cycle", 32'(prev_en), 32'd0);
      chk("en_match_request", 32'((q0.size() > 0 && en_match(q0[0])) || (q1.size() > 0 && en_match(q1[0]))), 32'd1);
      en_prev_cyc = en_last_cyc;
      en_last_cyc = cyc;
      en_cnt++;
    end
    prev_en = ctl_wr_enable | ctl_rd_enable;
  end

  int done_total = 0, done0_cnt = 0, done1_cnt = 0;
  bit glog [0:255];
  initial forever begin
    @(negedge clk_130mhz);
    if (req0_done) begin
      chk("done0_expected", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) begin
        if (!q0[0].we) chk("rdata0", 32'(req0_rdata), 32'(q0[0].rdata));
        void'(q0.pop_front());
      end
      glog[done_total & 255] = 1'b0;
      done_total++;
      done0_cnt++;
    end
    if (req1_done) begin
      chk("done1_expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        if (!q1[0].we) chk("rdata1", 32'(req1_rdata), 32'(q1[0].rdata));
        void'(q1.pop_front());
      end
      glog[done_total & 255] = 1'b1;
      done_total++;
      done1_cnt++;
    end
  end

  task automatic issue(input int p, input logic we, input logic [23:0] a, input logic [15:0] d);
    exp_t e;
    e.we = we; e.addr = a; e.wdata = d; e.rdata = mdata(a);
    if (p == 0) begin
      req0_we = we; req0_addr = a; req0_wdata = d; req0_valid = 1'b1; q0.push_back(e);
    end else begin
      req1_we = we; req1_addr = a; req1_wdata = d; req1_valid = 1'b1; q1.push_back(e);
    end
  endtask

  task automatic wait_done(input int p);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_130mhz);
      seen = (p == 0) ? req0_done : req1_done;
    end
    chk($sformatf("done%0d_within_budget", p), 32'(seen), 32'd1);
  endtask

  task automatic drop(input int p);
    if (p == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic port_run(input int p, input int n, input logic [23:0] base);
    for (int i = 0; i < n; i++) begin
      issue(p, (i % 2) == 0, base + 24'(i), 16'hC000 + 16'(p * 256 + i));
      wait_done(p);
    end
    drop(p);
  endtask

  task automatic chk_rst();
    chk("rst_wr_enable", 32'(ctl_wr_enable), 32'd0);
    chk("rst_rd_enable", 32'(ctl_rd_enable), 32'd0);
    chk("rst_done", 32'({req0_done, req1_done}), 32'd0);
    chk("rst_arb_active", 32'(arb_active), 32'd0);
    chk("rst_grant", 32'(grant), 32'd1);
    chk("rst_ctl_addr", 32'(ctl_addr), 32'd0);
    chk("rst_ctl_wdata", 32'(ctl_wdata), 32'd0);
    chk("rst_rdata", 32'({req0_rdata, req1_rdata}), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n_en, d0;
    bit ord [6];
    bit ok;
    reset = 1'b1;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;
    repeat (3) @(negedge clk_130mhz);
    chk_rst();
    reset = 1'b0;
    @(negedge clk_130mhz);

    // Both ports requesting back to back
    if (PRIO) ord = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    else      ord = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    base = done_total;
    fork
      port_run(0, PRIO ? 1 : 3, 24'h000200);
      port_run(1, PRIO ? 5 : 3, 24'h000300);
    join
    @(negedge clk_130mhz);
    chk("order_count", 32'(done_total - base), 32'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("order_%0d", i), 32'(glog[(base + i) & 255]), 32'(ord[i]));
    repeat (2) @(negedge clk_130mhz);

    // Single port-0 write, enable two cycles after the request
    issue(0, 1'b1, 24'h000123, 16'hBEEF);
    chk("wr_enable_early", 32'(ctl_wr_enable), 32'd0);
    @(negedge clk_130mhz);
    chk("wr_enable_latency", 32'(ctl_wr_enable), 32'd1);
    chk("wr_ctl_addr", 32'(ctl_addr), 32'h000123);
    chk("wr_ctl_wdata", 32'(ctl_wdata), 32'h0000BEEF);
    wait_done(0);
    drop(0);
    repeat (3) @(negedge clk_130mhz);
    chk("wr_addr_held", 32'(ctl_addr), 32'h000123);

    // Port-1 read, rdata held after done
    issue(1, 1'b0, 24'h000010, 16'h0000);
    wait_done(1);
    chk("rd1_rdata", 32'(req1_rdata), 32'h1234);
    drop(1);
    repeat (5) @(negedge clk_130mhz);
    chk("rd1_rdata_held", 32'(req1_rdata), 32'h1234);

    // First enable ignored by the controller; inputs change after latch
    n_en = en_cnt;
    d0 = done0_cnt;
    ign_target = ign_seen + 1;
    issue(0, 1'b1, 24'h000055, 16'hA5A5);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk_130mhz);
      ok = (en_cnt != n_en);
    end
    chk("reissue_first_enable", 32'(ok), 32'd1);
    req0_addr = 24'h000777;
    req0_wdata = 16'h0000;
    wait_done(0);
    drop(0);
    repeat (3) @(negedge clk_130mhz);
    chk("reissue_enable_count", 32'(en_cnt - n_en), 32'd2);
    chk("reissue_gap", 32'(en_last_cyc - en_prev_cyc), 32'(AT + 1));
    chk("reissue_done_count", 32'(done0_cnt - d0), 32'd1);

    // Controller busy while idle: no grant until busy drops
    force_busy = 1'b1;
    n_en = en_cnt;
    issue(0, 1'b0, 24'h000020, 16'h0000);
    repeat (6) @(negedge clk_130mhz);
    chk("busy_idle_no_enable", 32'(en_cnt - n_en), 32'd0);
    chk("busy_idle_inactive", 32'(arb_active), 32'd0);
    force_busy = 1'b0;
    @(negedge clk_130mhz);
    chk("busy_release_enable", 32'(ctl_rd_enable), 32'd1);
    wait_done(0);
    drop(0);
    repeat (2) @(negedge clk_130mhz);

    // Reset while a read waits for completion
    issue(0, 1'b0, 24'h000040, 16'h0000);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk_130mhz);
      ok = ctl_rd_enable;
    end
    chk("rst_case_enable", 32'(ok), 32'd1);
    repeat (2) @(negedge clk_130mhz);
    d0 = done0_cnt;
    reset = 1'b1;
    @(negedge clk_130mhz);
    chk_rst();
    q0.delete();
    req0_valid = 1'b0;
    @(negedge clk_130mhz);
    reset = 1'b0;
    repeat (4) @(negedge clk_130mhz);
    chk("rst_no_done", 32'(done0_cnt - d0), 32'd0);

    // Normal service after reset
    issue(0, 1'b0, 24'h000010, 16'h0000);
    wait_done(0);
    chk("post_rst_rdata0", 32'(req0_rdata), 32'h1234);
    drop(0);
    issue(1, 1'b1, 24'h000099, 16'h5555);
    wait_done(1);
    drop(1);
    repeat (3) @(negedge clk_130mhz);
    chk("scoreboard_empty", 32'(q0.size() + q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
